// File: rtl/risc16_pkg.sv
// risc16_pkg: opcode, ALU-op, sequencer state and trap-cause encodings for the risc16 control path
package risc16_pkg;
  localparam logic [3:0] OP_LW = 4'b0000;
  localparam logic [3:0] OP_SW = 4'b0001;
  localparam logic [3:0] OP_R_LO = 4'b0010;
  localparam logic [3:0] OP_R_HI = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_JMP = 4'b1101;
  localparam logic [1:0] ALU_OP_MEM = 2'b00;
  localparam logic [1:0] ALU_OP_BR = 2'b01;
  localparam logic [1:0] ALU_OP_R = 2'b10;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC = 3'd3;
  localparam logic [2:0] ST_MEM = 3'd4;
  localparam logic [2:0] ST_WB = 3'd5;
  localparam logic [2:0] ST_TRAP = 3'd6;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_IMEM = 2'b10;
  localparam logic [1:0] TC_DMEM = 2'b11;
  typedef struct packed {
    logic       jump;
    logic       beq;
    logic       bne;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } dec_t;
endpackage

// File: rtl/opcode_decoder.sv
// opcode_decoder: combinational opcode to decode-level bundle, shared with the single-cycle control path
module opcode_decoder
  import risc16_pkg::*;
(
  input  logic [3:0] opcode_i,
  output dec_t       dec_o,
  output logic       illegal_o
);
  logic is_r;
  always_comb begin
    is_r = opcode_i >= OP_R_LO && opcode_i <= OP_R_HI;
    dec_o = '0;
    dec_o.jump = opcode_i == OP_JMP;
    dec_o.beq = opcode_i == OP_BEQ;
    dec_o.bne = opcode_i == OP_BNE;
    dec_o.alu_src = opcode_i == OP_LW || opcode_i == OP_SW;
    dec_o.reg_dst = is_r;
    dec_o.mem_to_reg = opcode_i == OP_LW;
    dec_o.alu_op = is_r ? ALU_OP_R : (dec_o.beq || dec_o.bne) ? ALU_OP_BR : ALU_OP_MEM;
    illegal_o = !(dec_o.alu_src || is_r || dec_o.beq || dec_o.bne || dec_o.jump);
  end
endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with memory handshakes, timeout trap and retire counter
module multicycle_sequencer
  import risc16_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             branch_eval,
  output logic             jump,
  output logic             beq,
  output logic             bne,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);
  logic [2:0] state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [1:0] cause_q, cause_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic trap_q, trap_d, illegal, rdy, timeout, is_br, retire;
  dec_t dec, lv_q, lv_d;
  opcode_decoder u_dec (.opcode_i(opcode), .dec_o(dec), .illegal_o(illegal));
  always_comb begin
    rdy = state_q == ST_FETCH ? imem_ready : dmem_ready;
    timeout = !rdy && wcnt_q == 8'(WAIT_LIMIT - 1);
    is_br = lv_q.jump || lv_q.beq || lv_q.bne;
    retire = (state_q == ST_EXEC && is_br) || state_q == ST_WB ||
             (state_q == ST_MEM && !lv_q.mem_to_reg && dmem_ready);
    case (state_q)
      ST_IDLE:   state_d = run ? ST_FETCH : ST_IDLE;
      ST_FETCH:  state_d = imem_ready ? ST_DECODE : timeout ? ST_TRAP : ST_FETCH;
      ST_DECODE: state_d = illegal ? ST_TRAP : ST_EXEC;
      ST_EXEC:   state_d = lv_q.reg_dst ? ST_WB : ST_MEM;
      ST_MEM:    state_d = dmem_ready ? ST_WB : timeout ? ST_TRAP : ST_MEM;
      default:   state_d = state_q;
    endcase
    // every retiring state re-samples run at the instruction boundary
    if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    trap_d = trap_q || state_d == ST_TRAP;
    cause_d = (state_d == ST_TRAP && state_q != ST_TRAP) ?
              (state_q == ST_FETCH ? TC_IMEM : state_q == ST_MEM ? TC_DMEM : TC_ILLEGAL) : cause_q;
    wcnt_d = (state_q == ST_FETCH || state_q == ST_MEM) && !rdy ? wcnt_q + 8'd1 : 8'd0;
    lv_d = (state_d == ST_EXEC || state_d == ST_MEM || state_d == ST_WB) ?
           (state_q == ST_DECODE ? dec : lv_q) : '0;
    ret_d = retire ? ret_q + CNT_W'(1) : ret_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q <= '0;
      cause_q <= '0;
      trap_q <= 1'b0;
      lv_q <= '0;
      ret_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      cause_q <= cause_d;
      trap_q <= trap_d;
      lv_q <= lv_d;
      ret_q <= ret_d;
    end
  end
  assign imem_req = !reset && state_q == ST_FETCH;
  assign ir_write = imem_req && imem_ready;
  assign pc_inc = ir_write;
  assign branch_eval = !reset && state_q == ST_EXEC && is_br;
  assign mem_read = !reset && state_q == ST_MEM && lv_q.mem_to_reg;
  assign mem_write = !reset && state_q == ST_MEM && !lv_q.mem_to_reg;
  assign reg_write = !reset && state_q == ST_WB;
  assign busy = !reset && state_q != ST_IDLE && state_q != ST_TRAP;
  assign {jump, beq, bne, alu_src, reg_dst, mem_to_reg, alu_op} = lv_q;
  assign trap = trap_q;
  assign trap_cause = cause_q;
  assign retired = ret_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: instruction-level model expands a directed program into per-cycle inputs and expected outputs
module tb_multicycle_sequencer;
  localparam int WL = 15;
  localparam int CW = 4;
  localparam logic [3:0] LW = 4'h0, SW = 4'h1, ADD = 4'h2, BEQ = 4'hB, BNE = 4'hC, JMP = 4'hD;
  typedef struct packed {
    logic imem_req, ir_write, pc_inc, branch_eval, mem_read, mem_write, reg_write, busy, trap;
    logic [1:0] cause;
    logic [7:0] lv;
    logic [CW-1:0] retired;
  } obs_t;
  typedef struct packed {
    logic rst, run;
    logic [3:0] opc;
    logic ir, dr, full;
    obs_t exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset, run, imem_ready, dmem_ready;
  logic [3:0] opcode;
  logic imem_req, ir_write, pc_inc, branch_eval, jump, beq, bne, alu_src, reg_dst, mem_to_reg;
  logic mem_read, mem_write, reg_write, busy, trap;
  logic [1:0] alu_op, trap_cause;
  logic [CW-1:0] retired;
  obs_t act;
  vec_t vq[$];
  int cur = 0, n_vec = 0, n_bad = 0;
  logic active = 1'b0;
  logic m_trap, m_idle;
  logic [1:0] m_cause;
  logic [7:0] m_lv;
  logic [CW-1:0] m_ret;

  multicycle_sequencer #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .imem_req(imem_req), .ir_write(ir_write), .pc_inc(pc_inc),
    .branch_eval(branch_eval), .jump(jump), .beq(beq), .bne(bne), .alu_src(alu_src),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_op(alu_op), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .busy(busy), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  always #5 clk = ~clk;
  assign act = {imem_req, ir_write, pc_inc, branch_eval, mem_read, mem_write, reg_write, busy, trap,
                trap_cause, jump, beq, bne, alu_src, reg_dst, mem_to_reg, alu_op, retired};

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  // {jump,beq,bne,alu_src,reg_dst,mem_to_reg,alu_op}; all-zero marks an illegal opcode
  function automatic logic [7:0] levels(input logic [3:0] op);
    if (op == LW) return 8'b0001_0100;
    if (op == SW) return 8'b0001_0000;
    if (op >= 4'h2 && op <= 4'h9) return 8'b0000_1010;
    if (op == BEQ) return 8'b0100_0001;
    if (op == BNE) return 8'b0010_0001;
    if (op == JMP) return 8'b1000_0000;
    return 8'h00;
  endfunction

  function automatic obs_t mk(input logic b);
    obs_t o;
    o = '0;
    o.busy = b;
    o.trap = m_trap;
    o.cause = m_cause;
    o.lv = m_lv;
    o.retired = m_ret;
    return o;
  endfunction

  function automatic logic [7:0] strobes(input obs_t o);
    return {o.imem_req, o.ir_write, o.pc_inc, o.branch_eval, o.mem_read, o.mem_write, o.reg_write, o.busy};
  endfunction

  task automatic add(input logic rs, r, input logic [3:0] opc, input logic ir, dr, full, input obs_t o);
    vq.push_back({rs, r, opc, ir, dr, full, o});
  endtask

  task automatic retire_to(input logic r);
    m_ret = m_ret + 1'b1;
    m_lv = 8'h00;
    m_idle = !r;
  endtask

  task automatic rst_cyc(input logic rdy);
    add(1'b1, 1'b1, 4'h0, rdy, rdy, 1'b0, '0);
    m_ret = '0;
    m_trap = 1'b0;
    m_cause = 2'b00;
    m_lv = 8'h00;
    m_idle = 1'b1;
  endtask

  task automatic hold(input int k, input logic r);
    repeat (k) add(1'b0, r, 4'h0, 1'b0, 1'b0, 1'b1, mk(1'b0));
  endtask

  // iw/dw: ready-low cycles before completion; rm: run mid-instruction; re: run at the boundary
  task automatic instr(input logic [3:0] op, input int iw, input int dw, input logic rm, input logic re);
    obs_t o;
    logic [7:0] l;
    l = levels(op);
    if (m_idle) begin
      add(1'b0, 1'b1, op, 1'b0, 1'b0, 1'b1, mk(1'b0));
      m_idle = 1'b0;
    end
    for (int i = 0; i <= iw && i < WL; i++) begin
      o = mk(1'b1);
      o.imem_req = 1'b1;
      o.ir_write = (i == iw);
      o.pc_inc = (i == iw);
      add(1'b0, rm, op, i == iw, 1'b0, 1'b1, o);
    end
    if (iw >= WL) begin
      m_trap = 1'b1;
      m_cause = 2'b10;
      return;
    end
    add(1'b0, rm, op, 1'b0, 1'b0, 1'b1, mk(1'b1));
    if (l == 8'h00) begin
      m_trap = 1'b1;
      m_cause = 2'b01;
      return;
    end
    m_lv = l;
    o = mk(1'b1);
    if (op == BEQ || op == BNE || op == JMP) begin
      o.branch_eval = 1'b1;
      add(1'b0, re, op, 1'b0, 1'b0, 1'b1, o);
      retire_to(re);
      return;
    end
    add(1'b0, rm, op, 1'b0, 1'b0, 1'b1, o);
    if (op == LW || op == SW) begin
      for (int i = 0; i <= dw && i < WL; i++) begin
        o = mk(1'b1);
        o.mem_read = (op == LW);
        o.mem_write = (op == SW);
        add(1'b0, (op == SW && i == dw) ? re : rm, op, 1'b0, i == dw, 1'b1, o);
      end
      if (dw >= WL) begin
        m_trap = 1'b1;
        m_cause = 2'b11;
        m_lv = 8'h00;
        return;
      end
      if (op == SW) begin
        retire_to(re);
        return;
      end
    end
    o = mk(1'b1);
    o.reg_write = 1'b1;
    add(1'b0, re, op, 1'b0, 1'b0, 1'b1, o);
    retire_to(re);
  endtask

  always @(negedge clk) begin
    #2;
    if (active) begin
      if (vq[cur].full) chk($sformatf("cycle%0d", cur), 32'(act), 32'(vq[cur].exp));
      else chk($sformatf("reset_cycle%0d", cur), 32'(strobes(act)), 32'(strobes(vq[cur].exp)));
    end
  end

  initial begin
    int p, nr;
    reset = 1'b1; run = 1'b0; opcode = 4'h0; imem_ready = 1'b0; dmem_ready = 1'b0;
    rst_cyc(1'b0);
    hold(2, 1'b0);
    p = vq.size();
    instr(ADD, 0, 0, 1'b1, 1'b1);
    chk("pin_add_len", 32'(vq.size() - p), 32'd5);
    chk("pin_add_fetch", 32'(strobes(vq[p+1].exp)), 32'hE1);
    chk("pin_add_wb", 32'(vq[p+4].exp.reg_write), 32'd1);
    p = vq.size();
    instr(LW, 0, 3, 1'b1, 1'b1);
    nr = 0;
    for (int k = p; k < vq.size(); k++) nr += (vq[k].exp.mem_read && vq[k].exp.lv[2]) ? 1 : 0;
    chk("pin_lw_memread", 32'(nr), 32'd4);
    chk("pin_lw_len", 32'(vq.size() - p), 32'd8);
    p = vq.size();
    instr(BEQ, 0, 0, 1'b1, 1'b1);
    instr(JMP, 0, 0, 1'b1, 1'b1);
    chk("pin_beq_eval", 32'({vq[p+2].exp.branch_eval, vq[p+2].exp.lv[6]}), 32'd3);
    chk("pin_jmp_eval", 32'({vq[p+5].exp.branch_eval, vq[p+5].exp.lv[7]}), 32'd3);
    chk("pin_retired4", 32'(m_ret), 32'd4);
    instr(4'h5, 2, 0, 1'b0, 1'b1);
    instr(BNE, 1, 0, 1'b0, 1'b1);
    instr(SW, 0, 4, 1'b0, 1'b0);
    hold(3, 1'b0);
    instr(4'hE, 0, 0, 1'b1, 1'b1);
    chk("pin_illegal_cause", 32'(m_cause), 32'd1);
    hold(4, 1'b1);
    rst_cyc(1'b0);
    instr(4'hA, 0, 0, 1'b1, 1'b1);
    hold(2, 1'b1);
    rst_cyc(1'b0);
    instr(4'hF, 1, 0, 1'b1, 1'b1);
    hold(2, 1'b1);
    rst_cyc(1'b0);
    instr(ADD, 14, 0, 1'b1, 1'b1);
    p = vq.size();
    instr(ADD, 15, 0, 1'b1, 1'b1);
    chk("pin_imem_timeout", 32'({vq.size() - p, 2'(m_cause)}), 32'({32'd15, 2'b10}));
    hold(3, 1'b1);
    rst_cyc(1'b0);
    instr(SW, 0, 14, 1'b1, 1'b1);
    instr(LW, 0, 15, 1'b1, 1'b1);
    hold(2, 1'b1);
    rst_cyc(1'b0);
    instr(ADD, 0, 0, 1'b1, 1'b1);
    rst_cyc(1'b1);
    hold(1, 1'b0);
    repeat (17) instr(BEQ, 0, 0, 1'b1, 1'b1);
    chk("pin_wrap", 32'(m_ret), 32'd1);
    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      cur = k;
      active = 1'b1;
      {reset, run, opcode, imem_ready, dmem_ready} = {vq[k].rst, vq[k].run, vq[k].opc, vq[k].ir, vq[k].dr};
    end
    @(negedge clk);
    active = 1'b0;
    #1;
    chk("final_retired", 32'(retired), 32'd1);
    chk("final_fetch", 32'({busy, imem_req, trap}), 32'b110);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
